ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage: owns the architectural PC and feeds it to the NPC block.
//  Fetches the word at PC from instruction memory over a req/gnt/rvalid interface.
//  Presents {instr, instr_pc} to decode via a valid/ready handshake.
//  Loads PC from the NPC block's npc output when decode accepts the current instruction.
// PARAMETERS
//  PC_RESET    32'h0000_3000  PC value after reset
//  IMEM_WORDS  4096           legal fetch window is [PC_RESET, PC_RESET + 4*IMEM_WORDS)
//  NOP_WORD    32'h0000_0000  instr value driven on a fetch exception
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   asynchronous, active-low reset (0 = in reset)
//  pc           out  32  current PC; feeds the NPC block's pc input
//  npc          in   32  next PC from the NPC block; sampled only on accept
//  imem_req     out  1   fetch request
//  imem_addr    out  32  byte address of the fetch; equals pc
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   read data valid
//  imem_rdata   in   32  read data
//  instr_valid  out  1   instr/instr_pc/fetch_exc are valid
//  instr_ready  in   1   decode accepts the output this cycle
//  instr        out  32  fetched word, or NOP_WORD on exception
//  instr_pc     out  32  PC of the presented instr
//  fetch_exc    out  1   pc misaligned or outside the legal window
// BEHAVIOUR
//  Reset (reset=0), asynchronous: state=IDLE, pc=PC_RESET, instr_valid=0, imem_req=0,
//   instr=NOP_WORD, instr_pc=PC_RESET, fetch_exc=0.
//  FSM states: IDLE, REQ, WAIT, OUT.
//   IDLE -> REQ unconditionally. IDLE lasts exactly one cycle after reset release.
//   REQ, pc legal: imem_req=1. On imem_gnt go to WAIT; otherwise hold req and addr stable.
//   REQ, pc illegal (pc[1:0]!=0 or outside the window): imem_req=0. Go directly to OUT
//    with instr=NOP_WORD, fetch_exc=1.
//   WAIT: on imem_rvalid, capture instr=imem_rdata, instr_pc=pc, fetch_exc=0; go to OUT.
//   OUT: instr_valid=1. On instr_ready: pc<=npc and go to REQ. Otherwise hold all outputs stable.
//  At most one outstanding request. imem_rvalid is ignored in IDLE, REQ and OUT.
//  imem_rvalid is never expected in the same cycle as imem_gnt; earliest is the next cycle.
//  Minimum latency: reset release -> instr_valid is 3 cycles
//   (IDLE, REQ+gnt, WAIT+rvalid). Steady-state throughput is 1 instruction per 3 cycles.
//  pc changes only on accept (OUT & instr_ready) or on reset. npc is don't-care otherwise.
//  Window check uses 32-bit unsigned compare. PC_RESET + 4*IMEM_WORDS must not wrap 2^32.
//  npc=PC_RESET-4 or npc=0xFFFF_FFFC: the exception path is taken; no wrap to a legal address.
//  Reset asserted mid-WAIT: the late rvalid arrives in IDLE/REQ and is dropped.
//   The fetch restarts at PC_RESET.
//  instr_ready while instr_valid=0: no effect.
// STRUCTURE
//  Shared package cpu_defs: PC_RESET, NOP_WORD, the ifu_state_t enum {IDLE,REQ,WAIT,OUT},
//   and the pc_legal() window-check function (reused by the NPC and exception logic).
//  Sub-module pc_reg: 32-bit register with async active-low reset to PC_RESET and load enable.
//  Everything else is one FSM and an output register bank in ifu_fetch.
// TESTING
//  1. Release reset; gnt immediate; rvalid 1 cycle later with 0x3C01_1234; ready=1.
//     Expect imem_addr=0x3000, instr_valid on cycle 3 with instr=0x3C01_1234, instr_pc=0x3000.
//  2. Hold gnt=0 for 4 cycles in REQ.
//     Expect imem_req=1 and imem_addr=0x3000 stable throughout; no instr_valid.
//  3. instr_valid high with ready=0 for 5 cycles, npc changing each cycle.
//     Expect instr, instr_pc and pc stable. Raise ready with npc=0x3010: expect next imem_addr=0x3010.
//  4. Accept with npc=0x3002, then separately with npc=0x2FFC.
//     Expect no imem_req, fetch_exc=1, instr=0, instr_pc=npc.
//  5. Assert reset while in WAIT, then drive rvalid=1 after release.
//     Expect the rvalid dropped and the fetch restarted at 0x3000 with fresh data.
//  6. Accept at pc=0x3000+4*IMEM_WORDS-4 with npc=PC_RESET+4*IMEM_WORDS.
//     Expect the last word fetched normally, then fetch_exc=1 on the next fetch.

Source files
------------

// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared CPU constants, fetch FSM state type and PC window check.
// Revision    : 1.0
// ============================================================================
package cpu_defs;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam int unsigned IMEM_WORDS = 4096;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } ifu_state_t;

    // Word-aligned and inside [base, base + 4*words); caller guarantees no wrap.
    function automatic logic pc_legal(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] words);
        logic [31:0] limit;
        limit = base + (words << 2);
        return (pc[1:0] == 2'b00) && (pc >= base) && (pc < limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : 32-bit PC register, async active-low reset, load enable.
// Revision    : 1.0
// ============================================================================
module pc_reg #(
    parameter logic [31:0] RESET_VAL = cpu_defs::PC_RESET
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VAL;
        end else if (load_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch stage: PC ownership, imem req/gnt/rvalid
//               fetch and valid/ready presentation to decode.
// Revision    : 1.0
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] PC_RESET   = cpu_defs::PC_RESET,
    parameter int unsigned IMEM_WORDS = cpu_defs::IMEM_WORDS,
    parameter logic [31:0] NOP_WORD   = cpu_defs::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_exc
);

    import cpu_defs::*;

    localparam logic [31:0] C_WORDS = IMEM_WORDS;

    ifu_state_t  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        fetch_exc_q, fetch_exc_d;
    logic        pc_load;
    logic        pc_ok;

    pc_reg #(
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (pc_load),
        .d_i    (npc),
        .q_o    (pc)
    );

    assign pc_ok = pc_legal(pc, PC_RESET, C_WORDS);

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        fetch_exc_d = fetch_exc_q;
        pc_load     = 1'b0;
        imem_req    = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (pc_ok) begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        state_d = WAIT;
                    end
                end else begin
                    // Illegal PC never reaches memory; decode sees a NOP flagged as exception.
                    instr_d     = NOP_WORD;
                    instr_pc_d  = pc;
                    fetch_exc_d = 1'b1;
                    state_d     = OUT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d     = imem_rdata;
                    instr_pc_d  = pc;
                    fetch_exc_d = 1'b0;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (instr_ready) begin
                    pc_load = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            instr_q     <= NOP_WORD;
            instr_pc_q  <= PC_RESET;
            fetch_exc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            fetch_exc_q <= fetch_exc_d;
        end
    end

    assign imem_addr   = pc;
    assign instr_valid = (state_q == OUT);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_exc   = fetch_exc_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Scoreboard testbench for ifu_fetch with directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_ifu_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_exc;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_ipc;

    ifu_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .npc         (npc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fetch_exc   (fetch_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in REQ at a legal exp_pc; leaves the DUT in OUT.
    task automatic fetch(input logic [31:0] data, input int gnt_delay, input int rv_delay);
        for (int i = 0; i < gnt_delay; i++) begin
            instr_ready = 1'b1;
            chk("req_wait_req", {31'd0, imem_req}, 32'd1);
            chk("req_wait_addr", imem_addr, exp_pc);
            chk("req_wait_valid", {31'd0, instr_valid}, 32'd0);
            tick();
            chk("ready_no_effect_pc", pc, exp_pc);
        end
        instr_ready = 1'b0;
        chk("req_req", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, exp_pc);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < rv_delay; i++) begin
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        exp_instr   = data;
        exp_ipc     = exp_pc;
        sb_q.push_back('{instr: data, ipc: exp_pc, exc: 1'b0});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        chk("out_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    // Entered in REQ at an illegal exp_pc; leaves the DUT in OUT.
    task automatic exc_fetch();
        exp_instr = 32'h0;
        exp_ipc   = exp_pc;
        sb_q.push_back('{instr: 32'h0, ipc: exp_pc, exc: 1'b1});
        chk("exc_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("exc_valid", {31'd0, instr_valid}, 32'd1);
        chk("exc_flag", {31'd0, fetch_exc}, 32'd1);
    endtask

    task automatic accept(input logic [31:0] nv, input int hold);
        for (int i = 0; i < hold; i++) begin
            npc = $urandom;
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr, exp_instr);
            chk("hold_ipc", instr_pc, exp_ipc);
            tick();
            chk("hold_pc", pc, exp_pc);
        end
        chk("acc_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        npc         = nv;
        tick();
        instr_ready = 1'b0;
        npc         = $urandom;
        exp_pc      = nv;
        chk("acc_pc", pc, nv);
    endtask

    // Scoreboard monitor: one comparison set per accepted output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: output pc 0x%08h with empty scoreboard", instr_pc);
                end else begin
                    e = sb_q.pop_front();
                    chk("mon_instr", instr, e.instr);
                    chk("mon_ipc", instr_pc, e.ipc);
                    chk("mon_exc", {31'd0, fetch_exc}, {31'd0, e.exc});
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: timeout reached, 1 expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        npc         = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        exp_pc      = 32'h3000;
        exp_instr   = 32'h0;
        exp_ipc     = 32'h3000;

        #12;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ipc", instr_pc, 32'h3000);
        chk("rst_exc", {31'd0, fetch_exc}, 32'd0);

        // 1: minimum-latency fetch
        @(posedge clk); #1;
        reset = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        fetch(32'h3C01_1234, 0, 0);
        accept(32'h3004, 0);

        // 2: grant stall with ready toggled while nothing is valid
        fetch(32'h1111_2222, 4, 0);

        // 3: decode back-pressure with wandering npc
        accept(32'h3010, 5);
        fetch(32'h5555_0001, 1, 2);

        // 4: misaligned and below-window PCs
        accept(32'h3002, 0);
        exc_fetch();
        accept(32'h2FFC, 2);
        exc_fetch();
        accept(32'h3000, 0);

        // 5: reset during WAIT, late rvalid must be dropped
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h3000);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        tick();
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        chk("late_rv_req", {31'd0, imem_req}, 32'd1);
        chk("late_rv_addr", imem_addr, 32'h3000);
        tick();
        chk("late_rv_valid", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b0;
        exp_pc = 32'h3000;
        fetch(32'hAAAA_5555, 0, 0);

        // 6: top of window, then just past it, then top of address space
        accept(32'h6FFC, 0);
        fetch(32'h7777_6FFC, 0, 1);
        accept(32'h7000, 0);
        exc_fetch();
        accept(32'hFFFF_FFFC, 0);
        exc_fetch();
        accept(32'h3000, 0);
        tick();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
